// File: rtl/ps2_scancode_rx_pkg.sv
// Shared constants and types for the PS/2 scan-code receiver.
// Prefix bytes, common make codes, receiver FSM encoding and frame length.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;

    localparam logic [7:0] KEY_CAPS   = 8'h58;
    localparam logic [7:0] KEY_LSHIFT = 8'h12;
    localparam logic [7:0] KEY_RSHIFT = 8'h59;
    localparam logic [7:0] KEY_ENTER  = 8'h5A;
    localparam logic [7:0] KEY_BKSP   = 8'h66;

    localparam int FRAME_BITS = 11;
    localparam int KEY_W      = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } rx_state_t;

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// PS/2 pins plus decoded key/event outputs; master drives the pins, slave is the receiver.
interface ps2_scancode_rx_if;
    import ps2_pkg::*;

    logic             ps2_clk;
    logic             ps2_data;
    logic             done_key;
    logic [KEY_W-1:0] key_data;
    logic             frame_err;

    modport master (output ps2_clk, ps2_data, input  done_key, key_data, frame_err);
    modport slave  (input  ps2_clk, ps2_data, output done_key, key_data, frame_err);

endinterface

// File: rtl/ps2_scancode_rx_line_filter.sv
// Synchronises both PS/2 pins, debounces the clock and emits a one-cycle fall strobe.
// data_s is delayed one cycle so it lines up with the strobe.
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2Clk,
    input  logic ps2Data,
    output logic fall,
    output logic data_s
);
    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [1:0]       clkSync;
    logic [1:0]       dataSync;
    logic             clkFilt;
    logic [CNT_W-1:0] runCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            clkSync  <= 2'b11;
            dataSync <= 2'b11;
            clkFilt  <= 1'b1;
            runCnt   <= '0;
            fall     <= 1'b0;
            data_s   <= 1'b1;
        end else begin
            clkSync  <= {clkSync[0], ps2Clk};
            dataSync <= {dataSync[0], ps2Data};
            data_s   <= dataSync[1];
            fall     <= 1'b0;
            // Count a run of samples disagreeing with the filtered level; any agreement restarts it.
            if (clkSync[1] != clkFilt) begin
                if (runCnt == CNT_W'(FILTER_LEN - 1)) begin
                    clkFilt <= clkSync[1];
                    runCnt  <= '0;
                    fall    <= clkFilt;
                end else begin
                    runCnt <= runCnt + 1'b1;
                end
            end else begin
                runCnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: frames bytes, folds F0/E0 prefixes into {ext,brk,code}.
// done_key / frame_err strobe two cycles after the stop-bit fall; mid-frame silence aborts.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               rst,
    ps2_scancode_rx_if.slave   bus
);
    localparam int          TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0]  ST_IDLE  = IDLE;
    localparam logic [1:0]  ST_SHIFT = SHIFT;
    localparam logic [1:0]  ST_CHECK = CHECK;

    logic             fall;
    logic             dataS;
    logic [1:0]       state;
    logic [3:0]       bitCnt;
    logic [9:0]       shiftReg;
    logic [TO_W-1:0]  toCnt;
    logic             ext;
    logic             brk;
    logic             doneKey;
    logic             frameErr;
    logic [KEY_W-1:0] keyData;
    logic [7:0]       code;
    logic             frameOk;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk     (clk),
        .rst     (rst),
        .ps2Clk  (bus.ps2_clk),
        .ps2Data (bus.ps2_data),
        .fall    (fall),
        .data_s  (dataS)
    );

    // shiftReg after ten shifts: [9]=stop, [8]=parity, [7:0]=data
    assign code    = shiftReg[7:0];
    assign frameOk = (^shiftReg[8:0]) & shiftReg[9];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            bitCnt   <= '0;
            shiftReg <= '0;
            toCnt    <= '0;
            ext      <= 1'b0;
            brk      <= 1'b0;
            doneKey  <= 1'b0;
            frameErr <= 1'b0;
            keyData  <= '0;
        end else begin
            doneKey  <= 1'b0;
            frameErr <= 1'b0;
            if (fall || state != ST_SHIFT) toCnt <= '0;
            else                           toCnt <= toCnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (fall && !dataS) begin
                        state  <= ST_SHIFT;
                        bitCnt <= 4'd1;
                    end
                end
                ST_SHIFT: begin
                    if (fall) begin
                        shiftReg <= {dataS, shiftReg[9:1]};
                        bitCnt   <= bitCnt + 1'b1;
                        if (bitCnt == 4'd10) state <= ST_CHECK;
                    end else if (toCnt == TO_W'(TIMEOUT_CYCLES - 2)) begin
                        // Counter reaches TIMEOUT_CYCLES-1 on this edge; strobe lands exactly TIMEOUT_CYCLES after the fall.
                        state    <= ST_IDLE;
                        frameErr <= 1'b1;
                        ext      <= 1'b0;
                        brk      <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    state <= ST_IDLE;
                    if (!frameOk) begin
                        frameErr <= 1'b1;
                        ext      <= 1'b0;
                        brk      <= 1'b0;
                    end else if (code == PS2_BREAK) begin
                        brk <= 1'b1;
                    end else if (code == PS2_EXT) begin
                        ext <= 1'b1;
                    end else begin
                        keyData <= {ext, brk, code};
                        doneKey <= 1'b1;
                        ext     <= 1'b0;
                        brk     <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.done_key  = doneKey;
    assign bus.frame_err = frameErr;
    assign bus.key_data  = keyData;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Table-driven frames with a latency-aware scoreboard, plus timeout, glitch and reset sequences.
module tb_ps2_scancode_rx;
    import ps2_pkg::*;

    localparam int FLEN = 4;
    localparam int TO   = 200;
    localparam int HALF = 20;
    localparam int NVEC = 20;

    typedef struct {
        logic [7:0] code;
        bit         badPar;
        bit         badStop;
        bit         expEvt;
        bit         expErr;
        logic [9:0] expKey;
    } vec_t;

    typedef struct {
        bit         isErr;
        logic [9:0] key;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cycleCnt = 0;
    int   lastFall = 0;
    int   nChecks  = 0;
    int   nPass    = 0;
    exp_t sbq[$];
    vec_t vecs[NVEC];

    ps2_scancode_rx_if bus();

    ps2_scancode_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt++;

    task automatic check(input bit ok, input string name, input int act, input int expv);
        nChecks++;
        if (ok) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [10:0] frameBits(input logic [7:0] c, input bit badPar, input bit badStop);
        logic par;
        par = (~^c) ^ badPar;
        return {~badStop, par, c, 1'b0};
    endfunction

    task automatic sendBits(input logic [10:0] bits, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            bus.ps2_data = bits[i];
            if (glitch && (i == 3 || i == 7)) begin
                cyc(6);
                bus.ps2_clk = 1'b0;
                cyc(FLEN - 1);
                bus.ps2_clk = 1'b1;
                cyc(HALF - 6 - (FLEN - 1));
            end else begin
                cyc(HALF);
            end
            bus.ps2_clk = 1'b0;
            lastFall = cycleCnt;
            cyc(HALF);
            bus.ps2_clk = 1'b1;
        end
        cyc(10);
    endtask

    task automatic expectKey(input logic [9:0] k);
        sbq.push_back('{isErr: 1'b0, key: k, lat: FLEN + 4});
    endtask

    task automatic expectErr(input int lat);
        sbq.push_back('{isErr: 1'b1, key: 10'h000, lat: lat});
    endtask

    task automatic drain(input string name);
        int waited;
        waited = 0;
        while (sbq.size() != 0 && waited < 400) begin
            cyc(1);
            waited++;
        end
        check(sbq.size() == 0, name, sbq.size(), 0);
    endtask

    // Scoreboard: every strobe must match the head of the queue, including its latency.
    always @(negedge clk) begin
        if (!rst && (bus.done_key || bus.frame_err)) begin
            exp_t e;
            check(!(bus.done_key && bus.frame_err), "done_and_err", 1, 0);
            if (sbq.size() == 0) begin
                check(1'b0, "unexpected_strobe", int'(bus.key_data), 0);
            end else begin
                e = sbq.pop_front();
                check(bus.frame_err == e.isErr, "strobe_kind", int'(bus.frame_err), int'(e.isErr));
                if (!e.isErr)
                    check(bus.key_data == e.key, "key_data", int'(bus.key_data), int'(e.key));
                check((cycleCnt - lastFall) == e.lat, "latency", cycleCnt - lastFall, e.lat);
            end
        end
    end

    initial begin
        vecs[0]  = '{8'h1C, 0, 0, 1, 0, 10'h01C};
        vecs[1]  = '{8'hF0, 0, 0, 0, 0, 10'h000};
        vecs[2]  = '{8'h12, 0, 0, 1, 0, 10'h112};
        vecs[3]  = '{8'hE0, 0, 0, 0, 0, 10'h000};
        vecs[4]  = '{8'hF0, 0, 0, 0, 0, 10'h000};
        vecs[5]  = '{8'h75, 0, 0, 1, 0, 10'h375};
        vecs[6]  = '{8'h58, 0, 0, 1, 0, 10'h058};
        vecs[7]  = '{8'h58, 1, 0, 1, 1, 10'h000};
        vecs[8]  = '{8'h5A, 0, 0, 1, 0, 10'h05A};
        vecs[9]  = '{8'h58, 0, 1, 1, 1, 10'h000};
        vecs[10] = '{8'h5A, 0, 0, 1, 0, 10'h05A};
        vecs[11] = '{8'hAA, 0, 0, 1, 0, 10'h0AA};
        vecs[12] = '{8'hFA, 0, 0, 1, 0, 10'h0FA};
        vecs[13] = '{8'h1C, 0, 0, 1, 0, 10'h01C};
        vecs[14] = '{8'h1C, 0, 0, 1, 0, 10'h01C};
        vecs[15] = '{8'hE0, 0, 0, 0, 0, 10'h000};
        vecs[16] = '{8'h5A, 0, 0, 1, 0, 10'h25A};
        vecs[17] = '{8'hE0, 0, 0, 0, 0, 10'h000};
        vecs[18] = '{8'h5A, 1, 0, 1, 1, 10'h000};
        vecs[19] = '{8'h5A, 0, 0, 1, 0, 10'h05A};

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        rst = 1'b1;
        cyc(5);
        check(bus.done_key == 1'b0, "reset_done_key", int'(bus.done_key), 0);
        check(bus.frame_err == 1'b0, "reset_frame_err", int'(bus.frame_err), 0);
        check(bus.key_data == 10'h000, "reset_key_data", int'(bus.key_data), 0);
        rst = 1'b0;
        cyc(10);

        for (int v = 0; v < NVEC; v++) begin
            if (vecs[v].expEvt) begin
                if (vecs[v].expErr) expectErr(FLEN + 4);
                else                expectKey(vecs[v].expKey);
            end
            sendBits(frameBits(vecs[v].code, vecs[v].badPar, vecs[v].badStop), FRAME_BITS, 1'b0);
            drain("table_drain");
        end

        // Five bits then silence: abort exactly TIMEOUT_CYCLES after the last fall strobe.
        expectErr(FLEN + 2 + TO);
        sendBits(frameBits(KEY_CAPS, 0, 0), 5, 1'b0);
        cyc(TO + 50);
        drain("timeout_drain");
        expectKey({2'b00, KEY_BKSP});
        sendBits(frameBits(KEY_BKSP, 0, 0), FRAME_BITS, 1'b0);
        drain("after_timeout_drain");

        // Sub-threshold clock glitches during the high phase must be ignored.
        expectKey({2'b00, KEY_ENTER});
        sendBits(frameBits(KEY_ENTER, 0, 0), FRAME_BITS, 1'b1);
        drain("glitch_drain");

        // Reset mid-frame drops the partial frame.
        sendBits(frameBits(KEY_RSHIFT, 0, 0), 5, 1'b0);
        rst = 1'b1;
        cyc(3);
        check(bus.key_data == 10'h000, "midrst_key_data", int'(bus.key_data), 0);
        check(bus.done_key == 1'b0, "midrst_done_key", int'(bus.done_key), 0);
        check(bus.frame_err == 1'b0, "midrst_frame_err", int'(bus.frame_err), 0);
        rst = 1'b0;
        cyc(TO + 20);
        expectKey({2'b00, KEY_LSHIFT});
        sendBits(frameBits(KEY_LSHIFT, 0, 0), FRAME_BITS, 1'b0);
        drain("after_reset_drain");

        cyc(20);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
Receives PS/2 keyboard frames on the raw ps2_clk/ps2_data pins and decodes the make, break (F0) and extended (E0) prefix sequence. It presents one tagged scan code per key event on key_data, with a single-cycle done_key strobe. It sits directly upstream of the key/case state machine, which consumes done_key and key_data and compares key_data against plain 8-bit make codes (e.g. 8'h58 caps, 8'h12/8'h59 shift).

Parameters:
FILTER_LEN, 4, consecutive equal samples required before the filtered ps2_clk changes (glitch reject)
TIMEOUT_CYCLES, 50000, idle clk cycles mid-frame before the frame is aborted (1 ms at 50 MHz)

Ports:
clk  input  1  system clock; the only clock in the block
rst  input  1  synchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock pin, asynchronous
ps2_data  input  1  raw PS/2 data pin, asynchronous
done_key  output  1  one-cycle strobe: key_data is valid
key_data  output  10  {ext, brk, code[7:0]}; upper bits 0 for a plain make code
frame_err  output  1  one-cycle strobe: parity, stop or timeout error

Behaviour:
- Reset: rst is synchronous and active-high and wins over every other event.
- Reset values: done_key=0, frame_err=0, key_data=10'h000. FSM=IDLE, bit count=0, ext=0, brk=0.
- Sampling and filtering:
  - Both pins pass through a 2-flop synchronizer.
  - Filtered clock flips only after FILTER_LEN consecutive identical synchronized samples.
  - A fall strobe is one clk cycle, raised on a filtered 1->0 transition; data is sampled on that cycle.
- Frame format: 11 bits = start(0), 8 data LSB first, odd parity, stop(1).
- FSM states: IDLE, SHIFT, CHECK.
  - IDLE: on fall with data=0 -> SHIFT, count=1. On fall with data=1 -> stay IDLE (spurious, no error).
  - SHIFT: each fall shifts data in and increments count. On the fall with count==10 (stop bit) -> CHECK.
  - CHECK: lasts one cycle. The frame is good if XOR(data, parity)=1 and stop=1. Always returns to IDLE.
- Timeout:
  - The counter resets on every fall and counts while in SHIFT.
  - Reaching TIMEOUT_CYCLES-1 -> IDLE, frame_err pulse, ext and brk cleared.
  - The counter is idle in IDLE.
- Good frame, by code:
  - 8'hF0: brk<=1, no strobe.
  - 8'hE0: ext<=1, no strobe.
  - Any other code: key_data<={ext,brk,code}, done_key=1 for one cycle, then ext and brk cleared in the same cycle.
- Bad frame: frame_err=1 for one cycle; code discarded; ext and brk cleared.
- Latency: done_key rises exactly 1 clk after the CHECK cycle, i.e. 2 clk after the stop-bit fall strobe. frame_err has the same timing.
- key_data holds its value until the next done_key. done_key and frame_err are never high together.
- Typematic repeats: each repeated make frame produces its own done_key.
- 8'hAA (BAT) and 8'hFA (ack) are ordinary codes and are emitted.
- rst mid-frame: the partial frame is dropped, no strobe is issued, and the next start bit is decoded normally.
- Block is receive-only; it never drives the PS/2 lines.

Decomposition:
- Package ps2_pkg:
  - Prefix constants PS2_BREAK=8'hF0, PS2_EXT=8'hE0.
  - Scan-code constants KEY_CAPS=8'h58, KEY_LSHIFT=8'h12, KEY_RSHIFT=8'h59, KEY_ENTER=8'h5A, KEY_BKSP=8'h66.
  - rx_state_t enum {IDLE, SHIFT, CHECK}.
  - Frame-length constant 11.
- Sub-module ps2_line_filter: synchronizer, FILTER_LEN glitch filter and fall-strobe generator. Outputs fall and data_s.

Test Plan:
- Frame 0x1C, good parity -> done_key once, key_data=10'h01C, 2 clk after the stop fall; frame_err stays 0.
- Frames F0 then 12 -> one done_key only, key_data=10'h112; no strobe after the F0 frame.
- Frames E0, F0, 75 -> one done_key, key_data=10'h375; a following frame 58 -> key_data=10'h058 (flags cleared).
- Frame 0x58 with parity bit inverted -> frame_err pulse, no done_key; the next good 0x5A frame -> key_data=10'h05A. Repeat the check with stop=0.
- Five bits sent, then silence -> frame_err exactly TIMEOUT_CYCLES after the last fall; then a good 0x66 frame -> 10'h066.
- Glitch and reset cases:
  - ps2_clk low pulses of FILTER_LEN-1 cycles injected mid-frame -> decode unaffected.
  - rst asserted after bit 4 -> outputs 0, no strobe; the next 0x12 frame decodes to 10'h012.
